// File: rtl/store_unit_pkg.sv
// Shared store-path definitions: funct3 encodings, FSM state type and
// the access-size byte mask used to build write strobes.
package store_unit_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, ERR} state_t;

  // Zero mask marks an illegal store width.
  function automatic logic [3:0] size_mask(input logic [2:0] funct3);
    case (funct3)
      F3_SB:   size_mask = 4'b0001;
      F3_SH:   size_mask = 4'b0011;
      F3_SW:   size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane placement of a store: builds the 8-lane strobe and
// 64-bit data spanning two consecutive words, plus split/illegal flags.
module store_lane_align
  import store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] data,
  output logic [7:0]  s8,
  output logic [63:0] d64,
  output logic        split,
  output logic        illegal
);

  logic [3:0]  mask;
  logic [31:0] data_masked;

  assign mask = size_mask(funct3);

  // Lanes beyond the access width are forced to zero before shifting.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign data_masked[gi*8 +: 8] = mask[gi] ? data[gi*8 +: 8] : 8'h00;
  end

  assign illegal = (mask == 4'b0000);
  assign s8      = {4'b0000, mask} << off;
  assign d64     = {32'h0000_0000, data_masked} << {off, 3'b000};
  assign split   = (s8[7:4] != 4'b0000);

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts one store request, emits one or two aligned word
// beats with byte strobes, then pulses done (with err for rejected stores).
module store_unit
  import store_unit_pkg::*;
#(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        done,
  output logic        err
);

  state_t      state_reg, state_next;
  logic        mem_valid_reg, mem_valid_next;
  logic [31:0] mem_addr_reg, mem_addr_next;
  logic [31:0] mem_wdata_reg, mem_wdata_next;
  logic [3:0]  mem_wstrb_reg, mem_wstrb_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  logic [31:0] beat1_addr_reg, beat1_addr_next;
  logic [31:0] beat1_wdata_reg, beat1_wdata_next;
  logic [3:0]  beat1_wstrb_reg, beat1_wstrb_next;
  logic        split_reg, split_next;

  logic [7:0]  s8;
  logic [63:0] d64;
  logic        split;
  logic        illegal;
  logic [31:0] beat0_addr;

  store_lane_align u_align (
    .funct3  (req_funct3),
    .off     (req_addr[1:0]),
    .data    (req_data),
    .s8      (s8),
    .d64     (d64),
    .split   (split),
    .illegal (illegal)
  );

  assign beat0_addr = {req_addr[31:2], 2'b00};

  always_comb begin
    state_next       = state_reg;
    mem_valid_next   = mem_valid_reg;
    mem_addr_next    = mem_addr_reg;
    mem_wdata_next   = mem_wdata_reg;
    mem_wstrb_next   = mem_wstrb_reg;
    done_next        = 1'b0;
    err_next         = 1'b0;
    beat1_addr_next  = beat1_addr_reg;
    beat1_wdata_next = beat1_wdata_reg;
    beat1_wstrb_next = beat1_wstrb_reg;
    split_next       = split_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (illegal || (split && !SPLIT_MISALIGNED)) begin
            state_next = ERR;
            done_next  = 1'b1;
            err_next   = 1'b1;
          end else begin
            state_next       = BEAT0;
            mem_valid_next   = 1'b1;
            mem_addr_next    = beat0_addr;
            mem_wdata_next   = d64[31:0];
            mem_wstrb_next   = s8[3:0];
            beat1_addr_next  = beat0_addr + 32'd4;
            beat1_wdata_next = d64[63:32];
            beat1_wstrb_next = s8[7:4];
            split_next       = split;
          end
        end
      end
      BEAT0: begin
        if (mem_ready) begin
          if (split_reg) begin
            state_next     = BEAT1;
            mem_addr_next  = beat1_addr_reg;
            mem_wdata_next = beat1_wdata_reg;
            mem_wstrb_next = beat1_wstrb_reg;
          end else begin
            state_next     = IDLE;
            mem_valid_next = 1'b0;
            done_next      = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (mem_ready) begin
          state_next     = IDLE;
          mem_valid_next = 1'b0;
          done_next      = 1'b1;
        end
      end
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      mem_valid_reg   <= 1'b0;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
      mem_wstrb_reg   <= '0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
      beat1_addr_reg  <= '0;
      beat1_wdata_reg <= '0;
      beat1_wstrb_reg <= '0;
      split_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      mem_valid_reg   <= mem_valid_next;
      mem_addr_reg    <= mem_addr_next;
      mem_wdata_reg   <= mem_wdata_next;
      mem_wstrb_reg   <= mem_wstrb_next;
      done_reg        <= done_next;
      err_reg         <= err_next;
      beat1_addr_reg  <= beat1_addr_next;
      beat1_wdata_reg <= beat1_wdata_next;
      beat1_wstrb_reg <= beat1_wstrb_next;
      split_reg       <= split_next;
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign mem_valid = mem_valid_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_wstrb = mem_wstrb_reg;
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit: expected beats come from a byte-by-byte
// placement model; a second instance covers SPLIT_MISALIGNED=0.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_data;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        done, err;

  logic        n_req_valid, n_req_ready;
  logic        n_mem_valid, n_mem_ready;
  logic [31:0] n_mem_addr, n_mem_wdata;
  logic [3:0]  n_mem_wstrb;
  logic        n_done, n_err;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } beat_t;

  beat_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  store_unit #(.SPLIT_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_data(req_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .done(done), .err(err)
  );

  store_unit #(.SPLIT_MISALIGNED(1'b0)) dut_nosplit (
    .clk(clk), .rst(rst),
    .req_valid(n_req_valid), .req_ready(n_req_ready), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_data(req_data),
    .mem_valid(n_mem_valid), .mem_ready(n_mem_ready), .mem_addr(n_mem_addr),
    .mem_wdata(n_mem_wdata), .mem_wstrb(n_mem_wstrb), .done(n_done), .err(n_err)
  );

  // Place each stored byte at its absolute lane, then cut into word beats.
  function automatic void model_push(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] d);
    int          n;
    logic [7:0]  s;
    logic [63:0] w;
    beat_t       b;
    n = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
    s = '0;
    w = '0;
    for (int i = 0; i < n; i++) begin
      int p;
      p = int'(a[1:0]) + i;
      s[p] = 1'b1;
      w[p*8 +: 8] = d[i*8 +: 8];
    end
    b.addr  = {a[31:2], 2'b00};
    b.strb  = s[3:0];
    b.wdata = w[31:0];
    exp_q.push_back(b);
    if (s[7:4] != 4'b0000) begin
      b.addr  = {a[31:2], 2'b00} + 32'd4;
      b.strb  = s[7:4];
      b.wdata = w[63:32];
      exp_q.push_back(b);
    end
  endfunction

  task automatic drive_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    req_funct3 = f3;
    req_addr   = a;
    req_data   = d;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_valid, done, err, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
      failures++;
      $display("FAIL reset_outputs valid=%b done=%b err=%b addr=%h wdata=%h strb=%b required all zero",
               mem_valid, done, err, mem_addr, mem_wdata, mem_wstrb);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || mem_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready req_ready=%b mem_valid=%b required 1/0", req_ready, mem_valid);
    end
    $display("txn reset done");
    @(posedge clk);
    #1;
  endtask

  task automatic test_stores();
    logic [2:0]  f3 [8];
    logic [31:0] ad [8];
    logic [31:0] dt [8];
    int          lat [8];
    beat_t       eb;
    f3  = '{3'b000, 3'b001, 3'b010, 3'b000, 3'b001, 3'b010, 3'b001, 3'b010};
    ad  = '{32'h103, 32'h202, 32'h300, 32'h0, 32'h1, 32'h201, 32'hFFFF_FFFF, 32'h7};
    dt  = '{32'hAB, 32'hBEEF, 32'hDEAD_BEEF, 32'h1234_5677, 32'hFFFF_1234,
            32'h1122_3344, 32'hCAFE, 32'hA1B2_C3D4};
    lat = '{2, 2, 2, 2, 2, 3, 3, 3};
    mem_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      bit got;
      got = 1'b0;
      exp_q.delete();
      model_push(f3[t], ad[t], dt[t]);
      drive_req(f3[t], ad[t], dt[t]);
      for (int cyc = 1; cyc <= 8 && !got; cyc++) begin
        @(negedge clk);
        if (mem_valid) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL store%0d extra_beat addr=%h strb=%b wdata=%h", t, mem_addr, mem_wstrb, mem_wdata);
          end else begin
            eb = exp_q.pop_front();
            if (mem_addr !== eb.addr || mem_wstrb !== eb.strb || mem_wdata !== eb.wdata) begin
              failures++;
              $display("FAIL store%0d beat got addr=%h strb=%b wdata=%h required addr=%h strb=%b wdata=%h",
                       t, mem_addr, mem_wstrb, mem_wdata, eb.addr, eb.strb, eb.wdata);
            end
          end
        end
        if (done) begin
          got = 1'b1;
          checks++;
          if (cyc != lat[t] || err !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL store%0d done cycle=%0d err=%b beats_left=%0d required cycle=%0d err=0 beats_left=0",
                     t, cyc, err, exp_q.size(), lat[t]);
          end
          $display("txn store%0d f3=%b addr=%h data=%h done_cycle=%0d", t, f3[t], ad[t], dt[t], cyc);
        end
      end
      if (!got) begin
        checks++;
        failures++;
        $display("FAIL store%0d timeout no done required done at cycle %0d", t, lat[t]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_stall();
    beat_t eb;
    exp_q.delete();
    model_push(3'b010, 32'h300, 32'hDEAD_BEEF);
    eb = exp_q.pop_front();
    mem_ready = 1'b0;
    drive_req(3'b010, 32'h300, 32'hDEAD_BEEF);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      checks++;
      if (mem_valid !== 1'b1 || done !== 1'b0 || mem_addr !== eb.addr ||
          mem_wstrb !== eb.strb || mem_wdata !== eb.wdata) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d valid=%b done=%b addr=%h strb=%b wdata=%h required 1/0 %h %b %h",
                 cyc, mem_valid, done, mem_addr, mem_wstrb, mem_wdata, eb.addr, eb.strb, eb.wdata);
      end
    end
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || mem_valid !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL stall_release done=%b valid=%b err=%b required 1/0/0", done, mem_valid, err);
    end
    $display("txn stall sw addr=00000300 released after 3 wait cycles");
    @(posedge clk);
    #1;
  endtask

  task automatic test_illegal();
    logic [2:0] f3 [2];
    f3 = '{3'b011, 3'b111};
    mem_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      drive_req(f3[t], 32'h10, 32'h5555_AAAA);
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || err !== 1'b1 || mem_valid !== 1'b0 || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL illegal%0d err_cycle done=%b err=%b valid=%b ready=%b required 1/1/0/0",
                 t, done, err, mem_valid, req_ready);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || mem_valid !== 1'b0 || req_ready !== 1'b1) begin
        failures++;
        $display("FAIL illegal%0d after done=%b valid=%b ready=%b required 0/0/1", t, done, mem_valid, req_ready);
      end
      $display("txn illegal f3=%b err reported", f3[t]);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_no_split();
    beat_t eb;
    req_funct3  = 3'b010;
    req_addr    = 32'h2;
    req_data    = 32'h1122_3344;
    n_req_valid = 1'b1;
    @(posedge clk);
    #1;
    n_req_valid = 1'b0;
    for (int cyc = 1; cyc <= 2; cyc++) begin
      @(negedge clk);
      checks++;
      if (n_mem_valid !== 1'b0 || n_done !== (cyc == 1) || n_err !== (cyc == 1) || mem_valid !== 1'b0) begin
        failures++;
        $display("FAIL nosplit_err cycle=%0d valid=%b done=%b err=%b required valid=0 done=err=%0d",
                 cyc, n_mem_valid, n_done, n_err, cyc == 1);
      end
    end
    $display("txn nosplit sw addr=00000002 rejected");
    @(posedge clk);
    #1;
    exp_q.delete();
    model_push(3'b001, 32'h2, 32'h0000_77EE);
    eb = exp_q.pop_front();
    req_funct3  = 3'b001;
    req_data    = 32'h0000_77EE;
    n_req_valid = 1'b1;
    @(posedge clk);
    #1;
    n_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (n_mem_valid !== 1'b1 || n_mem_addr !== eb.addr || n_mem_wstrb !== eb.strb || n_mem_wdata !== eb.wdata) begin
      failures++;
      $display("FAIL nosplit_sh valid=%b addr=%h strb=%b wdata=%h required 1 %h %b %h",
               n_mem_valid, n_mem_addr, n_mem_wstrb, n_mem_wdata, eb.addr, eb.strb, eb.wdata);
    end
    @(negedge clk);
    checks++;
    if (n_done !== 1'b1 || n_err !== 1'b0) begin
      failures++;
      $display("FAIL nosplit_sh_done done=%b err=%b required 1/0", n_done, n_err);
    end
    $display("txn nosplit sh addr=00000002 single beat");
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f3 [3];
    logic [31:0] ad [3];
    logic [31:0] dt [3];
    beat_t       eb;
    int          idx, seen, lat, steps;
    bit          want_valid;
    f3 = '{3'b000, 3'b010, 3'b001};
    ad = '{32'h103, 32'h400, 32'h202};
    dt = '{32'h0000_00AB, 32'h0102_0304, 32'h0000_BEEF};
    exp_q.delete();
    mem_ready  = 1'b1;
    idx        = 1;
    seen       = 0;
    lat        = 0;
    steps      = 0;
    want_valid = 1'b1;
    model_push(f3[0], ad[0], dt[0]);
    drive_req(f3[0], ad[0], dt[0]);
    while (seen < 3 && steps < 40) begin
      @(negedge clk);
      steps++;
      lat++;
      if (want_valid) begin
        want_valid = 1'b0;
        checks++;
        if (mem_valid !== 1'b1) begin
          failures++;
          $display("FAIL b2b_bubble req=%0d valid=%b required 1 one cycle after accept", seen, mem_valid);
        end
      end
      if (mem_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL b2b extra_beat addr=%h strb=%b wdata=%h", mem_addr, mem_wstrb, mem_wdata);
        end else begin
          eb = exp_q.pop_front();
          if (mem_addr !== eb.addr || mem_wstrb !== eb.strb || mem_wdata !== eb.wdata) begin
            failures++;
            $display("FAIL b2b beat got addr=%h strb=%b wdata=%h required addr=%h strb=%b wdata=%h",
                     mem_addr, mem_wstrb, mem_wdata, eb.addr, eb.strb, eb.wdata);
          end
        end
      end
      if (done) begin
        checks++;
        if (lat != 2 || err !== 1'b0 || req_ready !== 1'b1) begin
          failures++;
          $display("FAIL b2b_done req=%0d cycle=%0d err=%b ready=%b required 2/0/1", seen, lat, err, req_ready);
        end
        $display("txn b2b req=%0d addr=%h done_cycle=%0d", seen, ad[seen], lat);
        seen++;
        if (idx < 3) begin
          model_push(f3[idx], ad[idx], dt[idx]);
          drive_req(f3[idx], ad[idx], dt[idx]);
          idx++;
          lat        = 0;
          want_valid = 1'b1;
        end
      end
    end
    if (seen < 3) begin
      checks++;
      failures++;
      $display("FAIL b2b timeout completed=%0d required 3", seen);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    beat_t eb;
    exp_q.delete();
    mem_ready = 1'b1;
    drive_req(3'b010, 32'h201, 32'h1122_3344);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h204) begin
      failures++;
      $display("FAIL rstmid_beat1 valid=%b addr=%h required 1 00000204", mem_valid, mem_addr);
    end
    mem_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (mem_valid !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_async valid=%b done=%b ready=%b required 0/0/1", mem_valid, done, req_ready);
    end
    rst = 1'b0;
    mem_ready = 1'b1;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || mem_valid !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_quiet cycle=%0d done=%b valid=%b required 0/0", cyc, done, mem_valid);
      end
    end
    model_push(3'b000, 32'h5, 32'h0000_005A);
    eb = exp_q.pop_front();
    drive_req(3'b000, 32'h5, 32'h0000_005A);
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b1 || mem_addr !== eb.addr || mem_wstrb !== eb.strb || mem_wdata !== eb.wdata) begin
      failures++;
      $display("FAIL rstmid_restart valid=%b addr=%h strb=%b wdata=%h required 1 %h %b %h",
               mem_valid, mem_addr, mem_wstrb, mem_wdata, eb.addr, eb.strb, eb.wdata);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_restart_done done=%b err=%b required 1/0", done, err);
    end
    $display("txn reset_mid abandoned split, restart sb addr=00000005");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    req_valid   = 1'b0;
    n_req_valid = 1'b0;
    req_funct3  = 3'b000;
    req_addr    = '0;
    req_data    = '0;
    mem_ready   = 1'b1;
    n_mem_ready = 1'b1;
    test_reset();
    test_stores();
    test_stall();
    test_illegal();
    test_no_split();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
